// File: rtl/reg_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial shifter.
package reg_serializer_pkg;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_e;

   localparam logic SER_LSB_FIRST = 1'b0;
   localparam logic SER_MSB_FIRST = 1'b1;

   localparam int SER_DATA_WIDTH_DEFAULT = 16;

   // Counter holds "bits remaining minus 1", so $clog2 of the width suffices.
   function automatic int ser_cnt_width(input int data_width);
      return (data_width < 2) ? 1 : $clog2(data_width);
   endfunction

   localparam int SER_CNT_W_DEFAULT = ser_cnt_width(SER_DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/reg_serializer_register.sv
// General-purpose register: synchronous clear, parallel load, and
// single-bit shift right (ir enters MSB) / shift left (il enters LSB).
module register #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cl,
   input  logic             ld,
   input  logic             sr,
   input  logic             sl,
   input  logic             ir,
   input  logic             il,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Priority: clear, then load, then right shift, then left shift.
   always_comb begin
      q_d = q_q;
      if (cl) begin
         q_d = '0;
      end else if (ld) begin
         q_d = d;
      end else if (sr) begin
         q_d = {ir, q_q[WIDTH-1:1]};
      end else if (sl) begin
         q_d = {q_q[WIDTH-2:0], il};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial shifter: takes one word over valid/ready and emits it
// one bit per accepted beat, LSB-first or MSB-first.
module reg_serializer
   import reg_serializer_pkg::*;
#(
   parameter int DATA_WIDTH = SER_DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cl,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   input  logic                  msb_first,
   output logic                  in_ready,
   output logic                  out_bit,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output ser_state_e            state_dbg,
   output logic [DATA_WIDTH-1:0] shreg_dbg
);

   localparam int CNT_W = ser_cnt_width(DATA_WIDTH);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid never depends combinationally on ready.
   ser_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   dir_q, dir_d;
   logic [DATA_WIDTH-1:0]  shreg_q;
   logic                   accept;
   logic                   beat;

   assign in_ready  = (state_q == SER_IDLE);
   assign out_valid = (state_q == SER_SHIFT);
   assign accept    = in_valid & in_ready;
   assign beat      = out_valid & out_ready;

   assign out_bit   = out_valid & ((dir_q == SER_MSB_FIRST) ? shreg_q[DATA_WIDTH-1]
                                                            : shreg_q[0]);
   assign out_last  = out_valid & (cnt_q == '0);

   // The register gives clear priority over load, so an abort wins.
   register #(
      .WIDTH (DATA_WIDTH)
   ) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .cl    (cl),
      .ld    (accept),
      .sr    (beat & (dir_q == SER_LSB_FIRST)),
      .sl    (beat & (dir_q == SER_MSB_FIRST)),
      .ir    (1'b0),
      .il    (1'b0),
      .d     (in),
      .q     (shreg_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (cl) begin
         state_d = SER_IDLE;
         cnt_d   = '0;
         dir_d   = SER_LSB_FIRST;
      end else begin
         case (state_q)
            SER_IDLE: begin
               if (accept) begin
                  state_d = SER_SHIFT;
                  cnt_d   = CNT_W'(DATA_WIDTH - 1);
                  dir_d   = msb_first;
               end
            end
            SER_SHIFT: begin
               // The final beat leaves instead of decrementing, so cnt never wraps.
               if (out_ready) begin
                  if (cnt_q == '0) begin
                     state_d = SER_IDLE;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
            end
            default: state_d = SER_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SER_IDLE;
         cnt_q   <= '0;
         dir_q   <= SER_LSB_FIRST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   assign state_dbg = state_q;
   assign shreg_dbg = shreg_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Randomised self-checking bench for reg_serializer with register loopback.
module tb_reg_serializer;
   import reg_serializer_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cl = 1'b0;
   logic [W-1:0]  in = '0;
   logic          in_valid = 1'b0;
   logic          msb_first = 1'b0;
   logic          in_ready;
   logic          out_bit;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   ser_state_e    state_dbg;
   logic [W-1:0]  shreg_dbg;
   logic          beat;
   logic [W-1:0]  lb_lsb_q, lb_msb_q;

   int checks_total  = 0;
   int checks_passed = 0;

   logic [W-1:0] exp_q[$];

   logic [W-1:0] got_bits, got_last, exp_v;
   int           got_beats, got_cycles, hold_err;

   always #5 clk = ~clk;

   reg_serializer #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cl        (cl),
      .in        (in),
      .in_valid  (in_valid),
      .msb_first (msb_first),
      .in_ready  (in_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .state_dbg (state_dbg),
      .shreg_dbg (shreg_dbg)
   );

   assign beat = out_valid & out_ready;

   register #(.WIDTH(W)) u_lb_lsb (
      .clk (clk), .rst_n (rst_n), .cl (1'b0), .ld (1'b0),
      .sr (beat), .sl (1'b0), .ir (out_bit), .il (1'b0),
      .d ('0), .q (lb_lsb_q)
   );

   register #(.WIDTH(W)) u_lb_msb (
      .clk (clk), .rst_n (rst_n), .cl (1'b0), .ld (1'b0),
      .sr (1'b0), .sl (beat), .ir (1'b0), .il (out_bit),
      .d ('0), .q (lb_msb_q)
   );

   // Reference: element k is the k-th bit on the wire.
   function automatic logic [W-1:0] model_order(input logic [W-1:0] word, input logic msb);
      logic [W-1:0] r;
      for (int k = 0; k < W; k++) r[k] = msb ? word[W-1-k] : word[k];
      return r;
   endfunction

   task automatic drive_word(input logic [W-1:0] word, input logic msb, input int mode,
                             input bit noise, input int abort_after);
      int   guard;
      logic prev_stall, prev_bit, prev_last;
      got_bits = '0; got_last = '0; got_beats = 0; got_cycles = 0; hold_err = 0;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      checks_total++;
      if (in_ready !== 1'b1) $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      else checks_passed++;
      in = word; msb_first = msb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; msb_first = ~msb; in = ~word;
      got_cycles = 1; prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
      while (got_beats < W && got_cycles < 300) begin
         if (prev_stall && (out_bit !== prev_bit || out_last !== prev_last || out_valid !== 1'b1))
            hold_err++;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (got_cycles % 3 == 1);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid && out_ready) begin
            got_bits[got_beats] = out_bit;
            got_last[got_beats] = out_last;
            got_beats++;
         end
         prev_stall = out_valid && !out_ready;
         prev_bit   = out_bit;
         prev_last  = out_last;
         if (noise) begin
            in_valid = 1'b1; in = W'($urandom); msb_first = 1'($urandom);
         end
         @(posedge clk); #1;
         got_cycles++;
         if (abort_after > 0 && got_beats == abort_after) break;
      end
      out_ready = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks_total++;
      if ({in_ready, out_valid, out_bit, out_last} !== 4'b1000)
         $display("FAIL reset_outputs: got %b required 1000", {in_ready, out_valid, out_bit, out_last});
      else checks_passed++;
      checks_total++;
      if (state_dbg !== SER_IDLE || shreg_dbg !== '0)
         $display("FAIL reset_state: state=%0d shreg=%h required 0/0000", state_dbg, shreg_dbg);
      else checks_passed++;
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lsb_vector();
      exp_q.push_back(model_order(16'hA5C3, SER_LSB_FIRST));
      drive_word(16'hA5C3, SER_LSB_FIRST, 0, 1'b0, 0);
      exp_v = exp_q.pop_front();
      checks_total++;
      if (got_bits !== exp_v) $display("FAIL lsb_bits: got %h required %h", got_bits, exp_v);
      else checks_passed++;
      checks_total++;
      if (got_last !== 16'h8000) $display("FAIL lsb_last: got %h required 8000", got_last);
      else checks_passed++;
      checks_total++;
      if (got_cycles !== 17 || in_ready !== 1'b1)
         $display("FAIL lsb_ready_return: cycle=%0d in_ready=%b required 17/1", got_cycles, in_ready);
      else checks_passed++;
      checks_total++;
      if (lb_lsb_q !== 16'hA5C3) $display("FAIL lsb_loopback: got %h required a5c3", lb_lsb_q);
      else checks_passed++;
   endtask

   task automatic test_msb_vector();
      exp_q.push_back(model_order(16'h8001, SER_MSB_FIRST));
      drive_word(16'h8001, SER_MSB_FIRST, 0, 1'b0, 0);
      exp_v = exp_q.pop_front();
      checks_total++;
      if (got_bits !== exp_v) $display("FAIL msb_bits: got %h required %h", got_bits, exp_v);
      else checks_passed++;
      checks_total++;
      if (got_last !== 16'h8000) $display("FAIL msb_last: got %h required 8000", got_last);
      else checks_passed++;
      checks_total++;
      if (lb_msb_q !== 16'h8001) $display("FAIL msb_loopback: got %h required 8001", lb_msb_q);
      else checks_passed++;
   endtask

   task automatic test_backpressure();
      exp_q.push_back(model_order(16'h00F0, SER_LSB_FIRST));
      drive_word(16'h00F0, SER_LSB_FIRST, 1, 1'b0, 0);
      exp_v = exp_q.pop_front();
      checks_total++;
      if (got_beats !== W || got_bits !== exp_v)
         $display("FAIL bp_bits: beats=%0d got %h required 16/%h", got_beats, got_bits, exp_v);
      else checks_passed++;
      checks_total++;
      if (hold_err !== 0) $display("FAIL bp_hold: hold errors=%0d required 0", hold_err);
      else checks_passed++;
      checks_total++;
      if (got_last !== 16'h8000) $display("FAIL bp_last: got %h required 8000", got_last);
      else checks_passed++;
   endtask

   task automatic test_abort();
      drive_word(16'h5A5A, SER_LSB_FIRST, 0, 1'b0, 5);
      cl = 1'b1;
      @(posedge clk); #1;
      cl = 1'b0;
      checks_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || shreg_dbg !== '0)
         $display("FAIL abort_idle: in_ready=%b out_valid=%b shreg=%h required 1/0/0000",
                  in_ready, out_valid, shreg_dbg);
      else checks_passed++;
      exp_q.push_back(model_order(16'h1234, SER_LSB_FIRST));
      drive_word(16'h1234, SER_LSB_FIRST, 0, 1'b0, 0);
      exp_v = exp_q.pop_front();
      checks_total++;
      if (got_bits !== exp_v) $display("FAIL abort_next_word: got %h required %h", got_bits, exp_v);
      else checks_passed++;
   endtask

   task automatic test_midword_reset();
      drive_word(16'hFFFF, SER_MSB_FIRST, 0, 1'b0, 5);
      rst_n = 1'b0;
      #1;
      checks_total++;
      if ({in_ready, out_valid, out_bit, out_last} !== 4'b1000)
         $display("FAIL midword_reset: got %b required 1000", {in_ready, out_valid, out_bit, out_last});
      else checks_passed++;
      #2; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_in_valid();
      exp_q.push_back(model_order(16'h3C69, SER_LSB_FIRST));
      drive_word(16'h3C69, SER_LSB_FIRST, 0, 1'b1, 0);
      exp_v = exp_q.pop_front();
      checks_total++;
      if (got_bits !== exp_v) $display("FAIL ignore_bits: got %h required %h", got_bits, exp_v);
      else checks_passed++;
      checks_total++;
      if (lb_lsb_q !== 16'h3C69) $display("FAIL ignore_loopback: got %h required 3c69", lb_lsb_q);
      else checks_passed++;
   endtask

   task automatic test_loopback();
      logic [W-1:0] words [3];
      logic [W-1:0] rx;
      words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         for (int d = 0; d < 2; d++) begin
            drive_word(words[i], 1'(d), 2, 1'b0, 0);
            rx = (d == 1) ? lb_msb_q : lb_lsb_q;
            checks_total++;
            if (rx !== words[i])
               $display("FAIL loopback_%s: got %h required %h", (d == 1) ? "msb" : "lsb", rx, words[i]);
            else checks_passed++;
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] w;
      logic         m;
      for (int i = 0; i < 8; i++) begin
         w = W'($urandom);
         m = 1'($urandom);
         exp_q.push_back(model_order(w, m));
         drive_word(w, m, 2, 1'(i % 2), 0);
         exp_v = exp_q.pop_front();
         checks_total++;
         if (got_bits !== exp_v || got_last !== 16'h8000)
            $display("FAIL random_word: word=%h dir=%b bits=%h last=%h required %h/8000",
                     w, m, got_bits, got_last, exp_v);
         else checks_passed++;
      end
   endtask

   initial begin
      test_reset();
      test_lsb_vector();
      test_msb_vector();
      test_backpressure();
      test_abort();
      test_midword_reset();
      test_ignore_in_valid();
      test_loopback();
      test_random();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
